telemetry_frame_tx: RTL and testbench

- Reader and transmitter for the registered 5:1 display mux.
- Drives the mux select itself and sweeps channels 0..4 (voltage, current, power, temperature, efficiency).
- Snapshots each 12-bit value, accounting for the mux's one-cycle registered latency.
- Sends the coherent snapshot as a fixed 12-byte frame over a UART 8N1 transmit line on a user IO pin.

---
 rtl/telemetry_frame_tx.sv | 169 ++++++++++++++++
 tb/tb_telemetry_frame_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_frame_tx.sv
// Scans the registered 5:1 display mux and sends a 12-byte UART frame (8N1).
// Define TELEM_PARITY_EN to insert an even-parity bit per byte (8E1).
`timescale 1ns/1ps
module telemetry_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic [11:0] mux_in,
  output logic [2:0]  select,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

`ifdef TELEM_PARITY_EN
  typedef enum logic [2:0] {IDLE, SCAN, START, DATA, PARITY, STOP, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SCAN, START, DATA, STOP, DONE} state_t;
`endif

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [3:0]  scan_cnt;
  logic [11:0] snap [5];
  logic [7:0]  chk;
  logic [7:0]  shreg;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [3:0]  byte_idx;
`ifdef TELEM_PARITY_EN
  logic        par;
`endif

  logic        bit_end;
  logic        in_bit;
  logic        load;
  logic [3:0]  next_idx;
  logic [2:0]  k;
  logic [11:0] snap_k;
  logic [7:0]  next_byte;

  // LOAD is folded into the transition to START so bytes stay back-to-back.
  always_comb begin
    bit_end  = (baud_cnt == BIT_LAST);
    in_bit   = (state == START) || (state == DATA) || (state == STOP)
`ifdef TELEM_PARITY_EN
               || (state == PARITY)
`endif
               ;
    load     = ((state == SCAN) && (scan_cnt == 4'd9)) ||
               ((state == STOP) && bit_end && (byte_idx != 4'd11));
    next_idx = (state == STOP) ? byte_idx + 4'd1 : 4'd0;
    k        = 3'((next_idx - 4'd1) >> 1);
    case (k)
      3'd0:    snap_k = snap[0];
      3'd1:    snap_k = snap[1];
      3'd2:    snap_k = snap[2];
      3'd3:    snap_k = snap[3];
      default: snap_k = snap[4];
    endcase
    next_byte = SYNC_BYTE;
    if (next_idx == 4'd11)
      next_byte = chk;
    else if (next_idx != 4'd0)
      next_byte = next_idx[0] ? {1'b0, k, snap_k[11:8]} : snap_k[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      select     <= 3'd0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      scan_cnt   <= 4'd0;
      chk        <= 8'd0;
      shreg      <= 8'd0;
      baud_cnt   <= 16'd0;
      bit_idx    <= 3'd0;
      byte_idx   <= 4'd0;
      for (int i = 0; i < 5; i++) snap[i] <= 12'd0;
`ifdef TELEM_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (in_bit) baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;

      case (state)
        IDLE: begin
          chk <= 8'd0;
          tx  <= 1'b1;
          if (trigger) begin
            state    <= SCAN;
            busy     <= 1'b1;
            select   <= 3'd0;
            scan_cnt <= 4'd0;
          end
        end
        // Each select value is held two cycles; the second edge sees the mux output.
        SCAN: begin
          scan_cnt <= scan_cnt + 4'd1;
          select   <= 3'((scan_cnt + 4'd1) >> 1);
          if (scan_cnt[0]) snap[scan_cnt[3:1]] <= mux_in;
          if (scan_cnt == 4'd9) select <= 3'd0;
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shreg[0];
            bit_idx <= 3'd0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef TELEM_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
              shreg   <= shreg >> 1;
            end
          end
        end
`ifdef TELEM_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end && (byte_idx == 4'd11)) begin
            state      <= DONE;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            tx         <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (load) begin
        state    <= START;
        tx       <= 1'b0;
        baud_cnt <= 16'd0;
        byte_idx <= next_idx;
        shreg    <= next_byte;
        if (next_idx != 4'd0 && next_idx != 4'd11) chk <= chk ^ next_byte;
`ifdef TELEM_PARITY_EN
        par      <= ^next_byte;
`endif
      end
    end
  end

endmodule

// File: tb/tb_telemetry_frame_tx.sv
// Directed bench for telemetry_frame_tx with a registered mux model and UART decoder.
`timescale 1ns/1ps
module tb_telemetry_frame_tx;
  localparam int CPB = 4;
`ifdef TELEM_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = 10 + 12 * NBITS * CPB;
  localparam logic [7:0] EXP_B [12] = '{8'hA5, 8'h01, 8'h23, 8'h10, 8'h45, 8'h2A,
                                        8'hBC, 8'h30, 8'h00, 8'h4F, 8'hFF, 8'h61};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic        noise = 1'b0;
  logic [11:0] mux_reg = 12'd0;
  logic [11:0] mux_in;
  logic [2:0]  select;
  logic        tx, busy, frame_done;
  int          total = 0;
  int          bad = 0;

  telemetry_frame_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .mux_in(mux_in),
    .select(select), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] mux_val(input logic [2:0] s);
    case (s)
      3'd0: return 12'h123;
      3'd1: return 12'h045;
      3'd2: return 12'hABC;
      3'd3: return 12'h000;
      3'd4: return 12'hFFF;
      default: return 12'h5A5;
    endcase
  endfunction

  // Registered mux model; noise corrupts its output outside the sample edges.
  always @(posedge clk) mux_reg <= mux_val(select);
  assign mux_in = noise ? ~mux_reg : mux_reg;

  // UART decoder sampling each bit mid-period on the falling clock edge.
  logic       rx_act = 1'b0;
  int         rx_cnt = 0;
  int         rx_n = 0;
  logic [7:0] rx_sh = 8'd0;
  logic [7:0] rx_byte [64];
  logic       rx_stop [64];
  logic       rx_par [64];

  always @(negedge clk) begin
    if (rst) begin
      rx_act <= 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act <= 1'b1;
        rx_cnt <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % CPB == CPB / 2) begin
        if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
          rx_sh[3'(rx_cnt / CPB - 1)] <= tx;
        else if (rx_cnt / CPB == NBITS - 1) begin
          rx_byte[6'(rx_n)] <= rx_sh;
          rx_stop[6'(rx_n)] <= tx;
          rx_n   <= rx_n + 1;
          rx_act <= 1'b0;
        end else if (rx_cnt / CPB == 9)
          rx_par[6'(rx_n)] <= tx;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  // Called in cycle 1 after acceptance; returns in the cycle after frame_done.
  task automatic run_frame(input bit with_noise, input bit retrig,
                           output int busy_cnt, output int fd_cnt, output int done_cyc,
                           output logic busy_at_done, output int sel_bad, output int tim_bad);
    logic prev_tx;
    busy_cnt = 0; fd_cnt = 0; done_cyc = 0; busy_at_done = 1'bx;
    sel_bad = 0; tim_bad = 0; prev_tx = tx;
    for (int c = 1; c <= FRAME_CYC + 2; c++) begin
      if (busy === 1'b1) busy_cnt++;
      if (c <= 10 && select !== 3'((c - 1) / 2)) sel_bad++;
      if (c > 10 && select !== 3'd0) sel_bad++;
      if (tx !== prev_tx && (c < 11 || ((c - 11) % CPB) != 0)) tim_bad++;
      prev_tx = tx;
      if (frame_done === 1'b1) begin
        fd_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          busy_at_done = busy;
        end
      end
      noise   = with_noise && (c > 10 || c[0]);
      trigger = retrig && (c == 50 || c == 300);
      if (c < FRAME_CYC + 2) step();
    end
    noise = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int base);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_byte[6'(base + i)]}, {24'd0, EXP_B[i]});
      check($sformatf("%s_stop%0d", tag, i), {31'd0, rx_stop[6'(base + i)]}, 32'd1);
`ifdef TELEM_PARITY_EN
      check($sformatf("%s_par%0d", tag, i), {31'd0, rx_par[6'(base + i)]}, {31'd0, ^EXP_B[i]});
`endif
    end
  endtask

  initial begin
    int bc, fc, dc, sb, tb_, base, hold_bad;
    logic bad_busy;

    // Reset state
    repeat (3) step();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_select", {29'd0, select}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    repeat (3) step();
    check("idle_tx", {31'd0, tx}, 32'd1);

    // Frame 1: select sweep, noise off the sample edges, retriggers while busy
    pulse_trigger();
    check("f1_busy_start", {31'd0, busy}, 32'd1);
    run_frame(1'b1, 1'b1, bc, fc, dc, bad_busy, sb, tb_);
    check("f1_busy_cycles", bc, FRAME_CYC);
    check("f1_done_pulses", fc, 1);
    check("f1_done_cycle", dc, FRAME_CYC + 1);
    check("f1_busy_at_done", {31'd0, bad_busy}, 32'd0);
    check("f1_select_sweep", sb, 0);
    check("f1_bit_timing", tb_, 0);
    check("f1_byte_count", rx_n, 12);
    check_frame("f1", 0);

    // Frame 2: trigger in the cycle after frame_done
    pulse_trigger();
    check("f2_busy_start", {31'd0, busy}, 32'd1);
    run_frame(1'b0, 1'b0, bc, fc, dc, bad_busy, sb, tb_);
    check("f2_busy_cycles", bc, FRAME_CYC);
    check("f2_done_pulses", fc, 1);
    check("f2_bit_timing", tb_, 0);
    check("f2_byte_count", rx_n, 24);
    check_frame("f2", 12);

    // Frame 3: reset during data bit 3 of byte 5
    pulse_trigger();
    repeat (10 + 5 * NBITS * CPB + 4 * CPB + 1) step();
    check("f3_busy_pre_rst", {31'd0, busy}, 32'd1);
    check("f3_tx_bit3", {31'd0, tx}, {31'd0, EXP_B[5][3]});
    rst = 1'b1;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_select", {29'd0, select}, 32'd0);
    step();
    step();
    rst = 1'b0;
    hold_bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) hold_bad++;
    end
    check("post_rst_idle", hold_bad, 0);
    check("post_rst_bytes", rx_n, 29);

    // Frame 4: full frame after the aborted one
    base = rx_n;
    pulse_trigger();
    run_frame(1'b0, 1'b0, bc, fc, dc, bad_busy, sb, tb_);
    check("f4_busy_cycles", bc, FRAME_CYC);
    check("f4_done_pulses", fc, 1);
    check("f4_select_sweep", sb, 0);
    check("f4_byte_count", rx_n, base + 12);
    check_frame("f4", base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
